// File: rtl/apb_pkg.sv
// Shared types and width helpers for the APB master multiplexer.
// Command layout is {write, strb, wdata, addr}; response layout is {err, rdata}.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_SLVERR  = 2'd1,
    ERR_DECERR  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } apb_err_e;

  function automatic int cmd_width(input int dw, input int aw);
    return 32'sd1 + dw / 32'sd8 + dw + aw;
  endfunction

  function automatic int resp_width(input int dw);
    return 32'sd2 + dw;
  endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Range check of an incoming address plus one-hot select and return-path mux
// for the slave addressed by the registered index.
module apb_slave_decoder #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int NS = 4,
  parameter int SW = 2
) (
  input  logic [AW-1:0]    addr_i,
  input  logic [SW-1:0]    idx_i,
  output logic             in_range_o,
  output logic [NS-1:0]    sel_o,
  input  logic [NS*DW-1:0] prdata_i,
  input  logic [NS-1:0]    pready_i,
  input  logic [NS-1:0]    pslverr_i,
  output logic [DW-1:0]    prdata_o,
  output logic             pready_o,
  output logic             pslverr_o
);

  // Only the addressed slave's return signals reach the master.
  always_comb begin
    in_range_o = ({{(32-SW){1'b0}}, addr_i[AW-1 -: SW]} < 32'(NS));
    sel_o      = '0;
    prdata_o   = '0;
    pready_o   = 1'b0;
    pslverr_o  = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (idx_i == SW'(k)) begin
        sel_o[k]  = 1'b1;
        prdata_o  = prdata_i[k*DW +: DW];
        pready_o  = pready_i[k];
        pslverr_o = pslverr_i[k];
      end else begin
        sel_o[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_master_mux.sv
// Single-outstanding APB master: accepts a command, runs SETUP/ACCESS on the
// slave chosen by the top address bits, and returns a registered response.
module apb_master_mux import apb_pkg::*; #(
  parameter int  DW  = 32,
  parameter int  AW  = 32,
  parameter int  NS  = 4,
  parameter int  TMO = 16,
  localparam int SW  = (NS > 1) ? $clog2(NS) : 1,
  localparam int CW  = cmd_width(DW, AW),
  localparam int RW  = resp_width(DW)
) (
  input  logic             pCLK,
  input  logic             pRESET,
  input  logic [CW-1:0]    i_cmd,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  output logic [RW-1:0]    o_resp,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [AW-1:0]    pADDR,
  output logic             pWRITE,
  output logic [DW-1:0]    pWDATA,
  output logic [DW/8-1:0]  pSTRB,
  output logic             pENABLE,
  output logic [NS-1:0]    pSEL,
  input  logic [NS*DW-1:0] pRDATA,
  input  logic [NS-1:0]    pREADY,
  input  logic [NS-1:0]    pSLVERR
);

  localparam int WCW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [WCW-1:0] TMO_LAST = WCW'((TMO > 0) ? TMO - 1 : 0);

  apb_state_e      state_q, state_d;
  logic [CW-1:0]   cmd_q, cmd_d;
  logic [RW-1:0]   resp_q, resp_d;
  logic [WCW-1:0]  wait_q, wait_d;

  logic            in_range_s;
  logic [NS-1:0]   sel_s;
  logic [DW-1:0]   rdata_s;
  logic            ready_s;
  logic            slverr_s;

  apb_slave_decoder #(.DW(DW), .AW(AW), .NS(NS), .SW(SW)) u_dec (
    .addr_i     (i_cmd[AW-1:0]),
    .idx_i      (cmd_q[AW-1 -: SW]),
    .in_range_o (in_range_s),
    .sel_o      (sel_s),
    .prdata_i   (pRDATA),
    .pready_i   (pREADY),
    .pslverr_i  (pSLVERR),
    .prdata_o   (rdata_s),
    .pready_o   (ready_s),
    .pslverr_o  (slverr_s)
  );

  // State register.
  always_ff @(posedge pCLK) begin
    if (pRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command, response and wait-counter registers.
  always_ff @(posedge pCLK) begin
    if (pRESET) begin
      cmd_q  <= '0;
      resp_q <= '0;
      wait_q <= '0;
    end else begin
      cmd_q  <= cmd_d;
      resp_q <= resp_d;
      wait_q <= wait_d;
    end
  end

  // Next-state and datapath updates; pREADY outranks the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    resp_d  = resp_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          cmd_d = i_cmd;
          if (in_range_s) begin
            state_d = ST_SETUP;
          end else begin
            state_d = ST_RESP;
            resp_d  = {ERR_DECERR, {DW{1'b0}}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        wait_d  = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (ready_s) begin
          state_d = ST_RESP;
          resp_d  = {(slverr_s ? ERR_SLVERR : ERR_OK),
                     (cmd_q[CW-1] ? {DW{1'b0}} : rdata_s)};
        end else if ((TMO > 0) && (wait_q == TMO_LAST)) begin
          state_d = ST_RESP;
          resp_d  = {ERR_TIMEOUT, {DW{1'b0}}};
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      ST_RESP: begin
        if (i_resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state and command.
  always_comb begin
    o_cmd_ready  = (state_q == ST_IDLE);
    o_resp_valid = (state_q == ST_RESP);
    o_resp       = resp_q;
    pADDR        = cmd_q[AW-1:0];
    pWDATA       = cmd_q[AW +: DW];
    pWRITE       = cmd_q[CW-1];
    pENABLE      = (state_q == ST_ACCESS);
    if (cmd_q[CW-1]) begin
      pSTRB = cmd_q[AW+DW +: DW/8];
    end else begin
      pSTRB = '0;
    end
    if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
      pSEL = sel_s;
    end else begin
      pSEL = '0;
    end
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench: a 4-slave master for the main scenarios and a 3-slave build
// for the out-of-range decode case.
module tb_apb_master_mux;

  logic         pCLK;
  logic         pRESET;

  logic [68:0]  i_cmd;
  logic         i_cmd_valid;
  logic         o_cmd_ready;
  logic [33:0]  o_resp;
  logic         o_resp_valid;
  logic         i_resp_ready;
  logic [31:0]  pADDR;
  logic         pWRITE;
  logic [31:0]  pWDATA;
  logic [3:0]   pSTRB;
  logic         pENABLE;
  logic [3:0]   pSEL;
  logic [127:0] pRDATA;
  logic [3:0]   pREADY;
  logic [3:0]   pSLVERR;

  logic [68:0]  c3_cmd;
  logic         c3_valid;
  logic         c3_ready;
  logic [33:0]  c3_resp;
  logic         c3_resp_valid;
  logic [31:0]  c3_addr;
  logic         c3_write;
  logic [31:0]  c3_wdata;
  logic [3:0]   c3_strb;
  logic         c3_enable;
  logic [2:0]   c3_sel;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc;

  apb_master_mux #(.DW(32), .AW(32), .NS(4), .TMO(16)) u_dut (
    .pCLK(pCLK), .pRESET(pRESET),
    .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .o_resp(o_resp), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .pADDR(pADDR), .pWRITE(pWRITE), .pWDATA(pWDATA), .pSTRB(pSTRB),
    .pENABLE(pENABLE), .pSEL(pSEL),
    .pRDATA(pRDATA), .pREADY(pREADY), .pSLVERR(pSLVERR)
  );

  apb_master_mux #(.DW(32), .AW(32), .NS(3), .TMO(16)) u_dut3 (
    .pCLK(pCLK), .pRESET(pRESET),
    .i_cmd(c3_cmd), .i_cmd_valid(c3_valid), .o_cmd_ready(c3_ready),
    .o_resp(c3_resp), .o_resp_valid(c3_resp_valid), .i_resp_ready(1'b1),
    .pADDR(c3_addr), .pWRITE(c3_write), .pWDATA(c3_wdata), .pSTRB(c3_strb),
    .pENABLE(c3_enable), .pSEL(c3_sel),
    .pRDATA({32'h1111_1111, 32'h2222_2222, 32'h3333_3333}),
    .pREADY(3'b111), .pSLVERR(3'b111)
  );

  initial pCLK = 1'b0;
  always #5 pCLK = ~pCLK;

  task automatic tick();
    @(posedge pCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    pRESET       = 1'b1;
    i_cmd        = '0;
    i_cmd_valid  = 1'b0;
    i_resp_ready = 1'b1;
    pRDATA       = '0;
    pREADY       = 4'b0000;
    pSLVERR      = 4'b0000;
    c3_cmd       = '0;
    c3_valid     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_psel",   64'(pSEL), 64'h0);
    chk("rst_penable", 64'(pENABLE), 64'h0);
    chk("rst_paddr",  64'(pADDR), 64'h0);
    chk("rst_pwdata", 64'(pWDATA), 64'h0);
    chk("rst_pstrb",  64'(pSTRB), 64'h0);
    chk("rst_pwrite", 64'(pWRITE), 64'h0);
    chk("rst_rvalid", 64'(o_resp_valid), 64'h0);
    chk("rst_resp",   64'(o_resp), 64'h0);
    pRESET = 1'b0;
    tick();
    chk("rst_cmd_ready", 64'(o_cmd_ready), 64'h1);

    // Zero-wait write to slave 1; other slaves assert SLVERR and must be ignored
    i_cmd       = {1'b1, 4'hF, 32'hDEAD_BEEF, 32'h4000_0010};
    i_cmd_valid = 1'b1;
    pREADY      = 4'b0010;
    pSLVERR     = 4'b1101;
    pRDATA      = {32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
    tick();
    i_cmd_valid = 1'b0;
    chk("wr_setup_psel",   64'(pSEL), 64'h2);
    chk("wr_setup_penable", 64'(pENABLE), 64'h0);
    chk("wr_setup_paddr",  64'(pADDR), 64'h4000_0010);
    chk("wr_setup_pwdata", 64'(pWDATA), 64'hDEAD_BEEF);
    chk("wr_setup_pstrb",  64'(pSTRB), 64'hF);
    chk("wr_setup_pwrite", 64'(pWRITE), 64'h1);
    chk("wr_setup_cready", 64'(o_cmd_ready), 64'h0);
    tick();
    chk("wr_access_psel",   64'(pSEL), 64'h2);
    chk("wr_access_penable", 64'(pENABLE), 64'h1);
    chk("wr_access_pwdata", 64'(pWDATA), 64'hDEAD_BEEF);
    tick();
    chk("wr_resp_valid",   64'(o_resp_valid), 64'h1);
    chk("wr_resp",         64'(o_resp), 64'h0);
    chk("wr_resp_psel",    64'(pSEL), 64'h0);
    chk("wr_resp_penable", 64'(pENABLE), 64'h0);
    tick();
    chk("wr_idle_cready", 64'(o_cmd_ready), 64'h1);
    chk("wr_idle_rvalid", 64'(o_resp_valid), 64'h0);

    // Read from slave 3 with 3 wait states, SLVERR, then response back-pressure
    i_cmd       = {1'b0, 4'hF, 32'h0000_0000, 32'hC000_0004};
    i_cmd_valid = 1'b1;
    pREADY      = 4'b0111;
    pSLVERR     = 4'b1000;
    pRDATA      = {32'h1234_5678, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
    tick();
    i_cmd_valid = 1'b0;
    chk("rd_setup_psel",  64'(pSEL), 64'h8);
    chk("rd_setup_pstrb", 64'(pSTRB), 64'h0);
    chk("rd_setup_pwrite", 64'(pWRITE), 64'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_penable", 64'(pENABLE), 64'h1);
      chk("rd_wait_psel",    64'(pSEL), 64'h8);
      chk("rd_wait_paddr",   64'(pADDR), 64'hC000_0004);
      tick();
    end
    pREADY       = 4'b1111;
    i_resp_ready = 1'b0;
    chk("rd_last_penable", 64'(pENABLE), 64'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rvalid", 64'(o_resp_valid), 64'h1);
      chk("bp_resp",   64'(o_resp), {30'h0, 2'd1, 32'h1234_5678});
      chk("bp_cready", 64'(o_cmd_ready), 64'h0);
      tick();
    end
    i_resp_ready = 1'b1;
    chk("bp_end_resp", 64'(o_resp), {30'h0, 2'd1, 32'h1234_5678});
    tick();
    chk("rd_idle_cready", 64'(o_cmd_ready), 64'h1);

    // Slave 0 never ready: 16 ACCESS cycles then TIMEOUT
    i_cmd       = {1'b0, 4'h0, 32'h0000_0000, 32'h0000_0100};
    i_cmd_valid = 1'b1;
    pREADY      = 4'b1110;
    pSLVERR     = 4'b1111;
    tick();
    i_cmd_valid = 1'b0;
    chk("tmo_setup_psel", 64'(pSEL), 64'h1);
    tick();
    n_acc = 0;
    while (pENABLE === 1'b1 && n_acc < 40) begin
      n_acc++;
      tick();
    end
    chk("tmo_access_cycles", 64'(n_acc), 64'd16);
    chk("tmo_rvalid", 64'(o_resp_valid), 64'h1);
    chk("tmo_resp",   64'(o_resp), {30'h0, 2'd3, 32'h0});
    chk("tmo_psel",   64'(pSEL), 64'h0);
    tick();

    // Following command to slave 2 completes normally
    i_cmd       = {1'b1, 4'h3, 32'h0BAD_F00D, 32'h8000_0020};
    i_cmd_valid = 1'b1;
    pREADY      = 4'b0100;
    pSLVERR     = 4'b1011;
    tick();
    i_cmd_valid = 1'b0;
    chk("post_setup_psel",  64'(pSEL), 64'h4);
    chk("post_setup_pstrb", 64'(pSTRB), 64'h3);
    tick();
    chk("post_access_penable", 64'(pENABLE), 64'h1);
    tick();
    chk("post_rvalid", 64'(o_resp_valid), 64'h1);
    chk("post_resp",   64'(o_resp), 64'h0);
    tick();

    // NS=3 build: slave index 3 is out of range -> DECERR at N+1 with no APB cycle
    c3_cmd   = {1'b0, 4'h0, 32'h0000_0000, 32'hC000_0000};
    c3_valid = 1'b1;
    tick();
    c3_valid = 1'b0;
    chk("dec_psel",    64'(c3_sel), 64'h0);
    chk("dec_penable", 64'(c3_enable), 64'h0);
    chk("dec_rvalid",  64'(c3_resp_valid), 64'h1);
    chk("dec_resp",    64'(c3_resp), {30'h0, 2'd2, 32'h0});
    tick();
    chk("dec_idle_cready", 64'(c3_ready), 64'h1);
    chk("dec_idle_rvalid", 64'(c3_resp_valid), 64'h0);

    // Reset asserted during ACCESS abandons the transfer
    i_cmd       = {1'b0, 4'h0, 32'h0000_0000, 32'h8000_0040};
    i_cmd_valid = 1'b1;
    pREADY      = 4'b0000;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    chk("mrst_access_penable", 64'(pENABLE), 64'h1);
    chk("mrst_access_psel",    64'(pSEL), 64'h4);
    pRESET = 1'b1;
    tick();
    chk("mrst_psel",    64'(pSEL), 64'h0);
    chk("mrst_penable", 64'(pENABLE), 64'h0);
    chk("mrst_rvalid",  64'(o_resp_valid), 64'h0);
    chk("mrst_paddr",   64'(pADDR), 64'h0);
    chk("mrst_resp",    64'(o_resp), 64'h0);
    pRESET = 1'b0;
    tick();
    chk("mrst_cready", 64'(o_cmd_ready), 64'h1);
    chk("mrst_rvalid_after", 64'(o_resp_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
